// File: rtl/riscp_pkg.sv
// Shared RISC front-end definitions: word width, NOP encoding, PC step and the fetch FSM states.
package riscp_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Prefetch queue of {pc, inst} pairs with wrap-around pointers, clear, and a head read port.
module instr_fifo
  import riscp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic                      i_clear,
  input  logic [2*XLEN-1:0]         i_push_data,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic [2*XLEN-1:0]         o_head_data,
  output logic                      o_head_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [2*XLEN-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [AW:0]       r_count;

  // Pointer and occupancy update; clear wins over push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else if (i_clear) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (i_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
    end
  end

  // Entry storage; data needs no reset because validity lives in r_count.
  always_ff @(posedge clk) begin
    if (rst && !i_clear && i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  assign o_count      = r_count;
  assign o_head_valid = (r_count != {(AW+1){1'b0}});
  assign o_head_data  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_prefetch.sv
// Instruction fetch front end: PC, one-outstanding fetch FSM, prefetch queue and redirect handling.
// Optional same-cycle bypass of the returning word to decode when PREFETCH_BYPASS_EN is defined.
module instr_prefetch
  import riscp_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e      r_state, w_state_next;
  logic [XLEN-1:0]   r_fetch_pc, w_fetch_pc_next;
  logic [XLEN-1:0]   r_addr, w_addr_next;
  logic              r_req, w_req_next;
  logic              w_push, w_pop, w_bypass;
  logic [CW-1:0]     w_count, w_count_next;
  logic [2*XLEN-1:0] w_head_data;
  logic              w_head_valid;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_clear      (redirect),
    .i_push_data  ({r_fetch_pc, imem_rdata}),
    .o_count      (w_count),
    .o_head_data  (w_head_data),
    .o_head_valid (w_head_valid)
  );

  // State register together with the registered request interface.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_addr     <= w_addr_next;
      r_req      <= w_req_next;
    end
  end

  assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

  // Next-state logic; redirect outranks both the returning response and queue traffic.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_addr_next     = r_addr;
    w_req_next      = r_req;
    case (r_state)
      S_IDLE: begin
        if (redirect) begin
          w_fetch_pc_next = redirect_pc;
          w_addr_next     = redirect_pc;
          w_req_next      = 1'b1;
          w_state_next    = S_WAIT;
        end else if (w_count_next < DEPTH_C) begin
          w_addr_next  = r_fetch_pc;
          w_req_next   = 1'b1;
          w_state_next = S_WAIT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          w_fetch_pc_next = redirect_pc;
          if (imem_ack) begin
            w_addr_next  = redirect_pc;
            w_state_next = S_WAIT;
          end else begin
            w_state_next = S_DROP;
          end
        end else if (imem_ack) begin
          w_fetch_pc_next = r_fetch_pc + PC_INC;
          if (w_count_next < DEPTH_C) begin
            w_addr_next  = r_fetch_pc + PC_INC;
            w_state_next = S_WAIT;
          end else begin
            w_req_next   = 1'b0;
            w_state_next = S_IDLE;
          end
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_DROP: begin
        // The stale request is still on the bus; only its completion lets us reissue.
        if (redirect) begin
          w_fetch_pc_next = redirect_pc;
          if (imem_ack) begin
            w_addr_next  = redirect_pc;
            w_state_next = S_WAIT;
          end else begin
            w_state_next = S_DROP;
          end
        end else if (imem_ack) begin
          w_addr_next  = r_fetch_pc;
          w_state_next = S_WAIT;
        end else begin
          w_state_next = S_DROP;
        end
      end
      default: begin
        w_req_next   = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output logic: queue push/pop strobes and the decode-facing head.
  always_comb begin
    w_bypass = 1'b0;
`ifdef PREFETCH_BYPASS_EN
    w_bypass = (w_count == {CW{1'b0}}) && (r_state == S_WAIT) && imem_ack && !redirect;
`endif
    w_pop  = w_head_valid && inst_ready && !redirect;
    w_push = (r_state == S_WAIT) && imem_ack && !redirect && !(w_bypass && inst_ready);
    if (w_bypass) begin
      inst_valid = 1'b1;
      inst       = imem_rdata;
      inst_pc    = r_fetch_pc;
    end else if (w_head_valid) begin
      inst_valid = 1'b1;
      inst       = w_head_data[XLEN-1:0];
      inst_pc    = w_head_data[2*XLEN-1:XLEN];
    end else begin
      inst_valid = 1'b0;
      inst       = NOP_INSTR;
      inst_pc    = {XLEN{1'b0}};
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign flush     = redirect;

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: directed scenarios plus randomized traffic against a queue model.
module tb_instr_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        flush;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of {pc, inst}, next fetch pc, outstanding request and whether it is stale.
  logic [63:0] m_q[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_addr = RESET_PC;
  bit          m_req = 1'b0;
  bit          m_drop = 1'b0;

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  function automatic bit e_byp();
`ifdef PREFETCH_BYPASS_EN
    return (m_q.size() == 0) && m_req && !m_drop && imem_ack && !redirect;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic e_valid();
    return (m_q.size() > 0) || e_byp();
  endfunction

  function automatic logic [31:0] e_inst();
    if (m_q.size() > 0) return m_q[0][31:0];
    else if (e_byp()) return imem_rdata;
    else return NOP;
  endfunction

  function automatic logic [31:0] e_pc();
    if (m_q.size() > 0) return m_q[0][63:32];
    else if (e_byp()) return m_pc;
    else return 32'h0;
  endfunction

  function automatic logic [98:0] exp_sig();
    return {m_req, (m_req ? m_addr : 32'h0), e_valid(), e_inst(), e_pc(), redirect};
  endfunction

  function automatic logic [98:0] got_sig();
    return {imem_req, (imem_req ? imem_addr : 32'h0), inst_valid, inst, inst_pc, flush};
  endfunction

  task automatic drive(input bit a_rst, input bit a_ack, input bit a_rdy,
                       input bit a_red, input logic [31:0] a_rpc);
    @(negedge clk);
    rst         = a_rst;
    imem_ack    = a_ack;
    inst_ready  = a_rdy;
    redirect    = a_red;
    redirect_pc = a_rpc;
    imem_rdata  = $urandom;
    #1;
  endtask

  // Advance one edge and apply the fetch rules to the model using the inputs of this cycle.
  task automatic tick();
    bit ack_e, byp;
    @(posedge clk);
    ack_e = imem_ack && m_req;
    byp   = e_byp();
    if (!rst) begin
      m_q.delete();
      m_pc = RESET_PC; m_addr = RESET_PC; m_req = 1'b0; m_drop = 1'b0;
    end else if (redirect) begin
      m_q.delete();
      m_pc = redirect_pc;
      if (!m_req) begin
        m_req = 1'b1; m_addr = redirect_pc; m_drop = 1'b0;
      end else if (ack_e) begin
        m_addr = redirect_pc; m_drop = 1'b0;
      end else begin
        m_drop = 1'b1;
      end
    end else begin
      if (m_q.size() > 0 && inst_ready) void'(m_q.pop_front());
      if (ack_e && !m_drop) begin
        if (!(byp && inst_ready)) m_q.push_back({m_pc, imem_rdata});
        m_pc = m_pc + 32'd4;
        if (m_q.size() < DEPTH) m_addr = m_pc;
        else m_req = 1'b0;
      end else if (ack_e && m_drop) begin
        m_drop = 1'b0; m_addr = m_pc;
      end else if (!m_req && m_q.size() < DEPTH) begin
        m_req = 1'b1; m_addr = m_pc;
      end
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({imem_req, imem_addr, inst_valid, inst, inst_pc} !== {1'b0, RESET_PC, 1'b0, NOP, 32'h0}) begin
      failures++;
      $display("FAIL reset_values got req=%b addr=%h v=%b inst=%h pc=%h expected 0/%h/0/%h/0",
               imem_req, imem_addr, inst_valid, inst, inst_pc, RESET_PC, NOP);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL req_at_E0 got %b expected 0", imem_req);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
      failures++; $display("FAIL req_after_E1 got %b/%h expected 1/%h", imem_req, imem_addr, RESET_PC);
    end
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
`ifdef PREFETCH_BYPASS_EN
      exp_pc = 32'(i) * 32'd4;
`else
      exp_pc = (i == 0) ? 32'h0 : 32'(i - 1) * 32'd4;
`endif
      checks++;
      if (got_sig() !== exp_sig()) begin
        failures++; $display("FAIL stream_model cyc=%0d got %h expected %h", i, got_sig(), exp_sig());
      end
      checks++;
      if ((i > 0) && ({inst_valid, inst_pc, flush} !== {1'b1, exp_pc, 1'b0})) begin
        failures++; $display("FAIL stream_pc cyc=%0d got v=%b pc=%h fl=%b expected 1/%h/0",
                             i, inst_valid, inst_pc, flush, exp_pc);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (got_sig() !== exp_sig()) begin
        failures++; $display("FAIL stall_model cyc=%0d got %h expected %h", i, got_sig(), exp_sig());
      end
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({imem_req, inst_valid, inst_pc, m_q.size() == DEPTH} !== {1'b0, 1'b1, 32'h0, 1'b1}) begin
      failures++; $display("FAIL stall_full got req=%b v=%b pc=%h qsize=%0d expected 0/1/0/%0d",
                           imem_req, inst_valid, inst_pc, m_q.size(), DEPTH);
    end
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({imem_req, imem_addr, inst_pc} !== {1'b1, 32'd16, 32'd4}) begin
      failures++; $display("FAIL stall_resume got req=%b addr=%h pc=%h expected 1/00000010/00000004",
                           imem_req, imem_addr, inst_pc);
    end
    tick();
  endtask

  task automatic test_redirect_drop();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    checks++;
    if ({flush, imem_req, imem_addr} !== {1'b1, 1'b1, 32'd8}) begin
      failures++; $display("FAIL drop_redirect got fl=%b req=%b addr=%h expected 1/1/00000008",
                           flush, imem_req, imem_addr);
    end
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({flush, inst_valid, imem_addr} !== {1'b0, 1'b0, 32'd8}) begin
      failures++; $display("FAIL drop_stale got fl=%b v=%b addr=%h expected 0/0/00000008",
                           flush, inst_valid, imem_addr);
    end
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({imem_req, imem_addr, flush} !== {1'b1, 32'h100, 1'b0}) begin
      failures++; $display("FAIL drop_target_addr got req=%b addr=%h expected 1/00000100", imem_req, imem_addr);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h100}) begin
      failures++; $display("FAIL drop_target_pc got v=%b pc=%h expected 1/00000100", inst_valid, inst_pc);
    end
    tick();
  endtask

  task automatic test_redirect_full();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0); tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
    checks++;
    if (got_sig() !== exp_sig()) begin
      failures++; $display("FAIL redir_ack_model got %h expected %h", got_sig(), exp_sig());
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({inst_valid, inst, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, 32'h200}) begin
      failures++; $display("FAIL redir_ack got v=%b inst=%h req=%b addr=%h expected 0/%h/1/00000200",
                           inst_valid, inst, imem_req, imem_addr, NOP);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({imem_req, imem_addr, inst_pc} !== {1'b1, 32'h0, 32'hFFFF_FFFC}) begin
      failures++; $display("FAIL pc_wrap got req=%b addr=%h pc=%h expected 1/00000000/fffffffc",
                           imem_req, imem_addr, inst_pc);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit byp_exp;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({imem_req, imem_addr, inst_valid, inst, inst_pc} !== {1'b0, RESET_PC, 1'b0, NOP, 32'h0}) begin
      failures++; $display("FAIL mid_reset got req=%b addr=%h v=%b inst=%h pc=%h",
                           imem_req, imem_addr, inst_valid, inst, inst_pc);
    end
    tick();
`ifdef PREFETCH_BYPASS_EN
    byp_exp = 1'b1;
`else
    byp_exp = 1'b0;
`endif
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, RESET_PC, byp_exp}) begin
      failures++; $display("FAIL restart got req=%b addr=%h v=%b expected 1/%h/%b",
                           imem_req, imem_addr, inst_valid, RESET_PC, byp_exp);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | {$urandom_range(0, 3), 2'b00})
                                          : {$urandom_range(0, 1023), 2'b00};
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0, rpc);
      checks++;
      if (got_sig() !== exp_sig()) begin
        failures++; $display("FAIL random cyc=%0d got %h expected %h", i, got_sig(), exp_sig());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_full();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
